wavetable_nco: RTL and testbench



---
 rtl/wavetable_nco.sv | 123 ++++++++++++
 tb/tb_wavetable_nco.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wavetable_nco.sv
`default_nettype none
// ============================================================================
// Module      : wavetable_nco
// Description : Phase-accumulator oscillator with fractional phase, three
//               boundary modes (wrap / bounce / hold), a boundary-event pulse
//               and a two-stage wavetable lookup with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wavetable_nco #(
  parameter int ACC_W  = 9,
  parameter int INCR_W = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              preload,
  input  logic [ACC_W-1:0]  pl_data,
  input  logic              updn,
  input  logic [INCR_W-1:0] incr,
  input  logic [1:0]        mode,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_din,
  output logic [ACC_W-1:0]  phase,
  output logic              dir,
  output logic              wrapped,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid
);

  localparam logic [ACC_W-1:0] c_max         = '1;
  localparam logic [1:0]       c_mode_bounce = 2'd1;
  localparam logic [1:0]       c_mode_hold   = 2'd2;

  logic [ACC_W-1:0]  r_phase;
  logic              r_flip;
  logic              r_wrapped;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_sample;
  logic [1:0]        r_valid_sr;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic [ACC_W-1:0]  w_incr_n;
  logic [ACC_W:0]    w_sum;
  logic              w_dir;
  logic              w_ovf;
  logic              w_unf;
  logic [ACC_W-1:0]  w_next;
  logic [ADDR_W-1:0] w_index;

  // Step arithmetic: the carry of an ACC_W+1 bit sum flags overflow, a plain
  // magnitude compare flags underflow. Landing exactly on 0 or MAX is neither.
  assign w_incr_n = ACC_W'(incr);
  assign w_sum    = {1'b0, r_phase} + {1'b0, w_incr_n};
  assign w_dir    = (mode == c_mode_bounce) ? (updn ^ r_flip) : updn;
  assign w_ovf    = w_dir & w_sum[ACC_W];
  assign w_unf    = ~w_dir & (w_incr_n > r_phase);

  // Top ADDR_W bits index the table; the remaining low bits are fractional.
  assign w_index  = r_phase[ACC_W-1 -: ADDR_W];

  // Next phase for an enabled step, selected by boundary mode.
  always_comb begin
    w_next = w_dir ? w_sum[ACC_W-1:0] : (r_phase - w_incr_n);
    case (mode)
      c_mode_bounce: begin
        // Reflect off MAX: MAX-(sum-MAX) reduces to MAX-1-(sum mod 2**ACC_W).
        if (w_ovf)      w_next = c_max - 1'b1 - w_sum[ACC_W-1:0];
        else if (w_unf) w_next = w_incr_n - r_phase;
      end
      c_mode_hold: begin
        if (w_ovf)      w_next = c_max;
        else if (w_unf) w_next = '0;
      end
      default: ;
    endcase
  end

  // Phase, bounce flip state and boundary pulse; preload beats enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_flip    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (preload) begin
      r_phase   <= pl_data;
      r_flip    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_wrapped <= enable & (w_ovf | w_unf);
      if (enable) r_phase <= w_next;
      if (mode != c_mode_bounce) r_flip <= 1'b0;
      else if (enable && (w_ovf || w_unf)) r_flip <= ~r_flip;
    end
  end

  // Wavetable: write port and read-before-write synchronous read (not reset).
  always_ff @(posedge clk) begin
    if (tbl_we) r_mem[tbl_addr] <= tbl_din;
    r_rd_data <= r_mem[w_index];
  end

  // Output sample register and pipeline-fill shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample   <= '0;
      r_valid_sr <= 2'b00;
    end else begin
      r_sample   <= r_rd_data;
      r_valid_sr <= {r_valid_sr[0], 1'b1};
    end
  end

  assign phase        = r_phase;
  assign dir          = w_dir;
  assign wrapped      = r_wrapped;
  assign sample       = r_sample;
  assign sample_valid = r_valid_sr[1];

endmodule
`default_nettype wire

// File: tb/tb_wavetable_nco.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavetable_nco
// Description : Directed self-checking bench for wavetable_nco with a sample
//               scoreboard fed from a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavetable_nco;

  typedef struct {
    bit          known;
    logic [31:0] val;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        preload = 1'b0;
  logic [8:0]  pl_data = '0;
  logic        updn = 1'b1;
  logic [3:0]  incr = '0;
  logic [1:0]  mode = '0;
  logic        tbl_we = 1'b0;
  logic [7:0]  tbl_addr = '0;
  logic [31:0] tbl_din = '0;
  logic [8:0]  phase;
  logic        dir;
  logic        wrapped;
  logic [31:0] sample;
  logic        sample_valid;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_mem [256];
  bit          model_known [256];
  logic [8:0]  m_phase = '0;
  sb_entry_t   sb [$];

  wavetable_nco dut (
    .clk(clk), .reset(reset), .enable(enable), .preload(preload),
    .pl_data(pl_data), .updn(updn), .incr(incr), .mode(mode),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_din(tbl_din),
    .phase(phase), .dir(dir), .wrapped(wrapped), .sample(sample),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pre, input logic [8:0] pl, input logic en,
                       input logic up, input logic [3:0] inc, input logic [1:0] md);
    preload = pre; pl_data = pl; enable = en; updn = up; incr = inc; mode = md;
  endtask

  // One clock: push the lookup the DUT performs on this edge, update the
  // table model, then check phase/dir/wrapped and the sample due now.
  task automatic tick(input logic [8:0] exp_ph, input logic exp_dir, input logic exp_wr);
    sb_entry_t e;
    sb_entry_t got;
    e.known = model_known[m_phase[8:1]];
    e.val   = model_mem[m_phase[8:1]];
    sb.push_back(e);
    if (tbl_we) begin
      model_mem[tbl_addr]   = tbl_din;
      model_known[tbl_addr] = 1'b1;
    end
    @(posedge clk); #1;
    m_phase = exp_ph;
    check("phase",   32'(phase),   32'(exp_ph));
    check("dir",     32'(dir),     32'(exp_dir));
    check("wrapped", 32'(wrapped), 32'(exp_wr));
    if (sb.size() >= 2) begin
      got = sb.pop_front();
      check("sample_valid", 32'(sample_valid), 32'd1);
      if (got.known) check("sample", sample, got.val);
    end else begin
      check("sample_valid_low", 32'(sample_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;

    // Reset state
    #12;
    check("rst_phase",   32'(phase),        32'd0);
    check("rst_sample",  sample,            32'd0);
    check("rst_valid",   32'(sample_valid), 32'd0);
    check("rst_wrapped", 32'(wrapped),      32'd0);
    @(negedge clk); reset = 1'b0;

    // Load table with 3*i while the accumulator idles at 0
    for (int i = 0; i < 256; i++) begin
      tbl_we = 1'b1; tbl_addr = 8'(i); tbl_din = 32'(3 * i);
      tick(9'd0, 1'b1, 1'b0);
    end
    tbl_we = 1'b0;

    // Basic up-count with incr 4; samples follow the table with 2-cycle lag
    drive(1, 9'd0, 0, 1, 4'd0, 2'd0); tick(9'd0, 1'b1, 1'b0);
    drive(0, 9'd0, 1, 1, 4'd4, 2'd0);
    for (int k = 1; k <= 8; k++) tick(9'(4 * k), 1'b1, 1'b0);

    // Wrap mode up and down
    drive(1, 9'd508, 0, 1, 4'd7, 2'd0); tick(9'd508, 1'b1, 1'b0);
    drive(0, 9'd0,   1, 1, 4'd7, 2'd0); tick(9'd3,   1'b1, 1'b1);
    drive(0, 9'd0,   0, 1, 4'd7, 2'd0); tick(9'd3,   1'b1, 1'b0);
    drive(1, 9'd2,   0, 0, 4'd5, 2'd0); tick(9'd2,   1'b0, 1'b0);
    drive(0, 9'd0,   1, 0, 4'd5, 2'd0); tick(9'd509, 1'b0, 1'b1);
    drive(0, 9'd0,   0, 0, 4'd5, 2'd0); tick(9'd509, 1'b0, 1'b0);

    // Bounce mode
    drive(1, 9'd508, 0, 1, 4'd7, 2'd1); tick(9'd508, 1'b1, 1'b0);
    drive(0, 9'd0,   1, 1, 4'd7, 2'd1); tick(9'd507, 1'b0, 1'b1);
    tick(9'd500, 1'b0, 1'b0);
    drive(1, 9'd3,   0, 0, 4'd7, 2'd1); tick(9'd3,   1'b0, 1'b0);
    drive(0, 9'd0,   1, 0, 4'd7, 2'd1); tick(9'd4,   1'b1, 1'b1);
    drive(1, 9'd504, 0, 1, 4'd7, 2'd1); tick(9'd504, 1'b1, 1'b0);
    drive(0, 9'd0,   1, 1, 4'd7, 2'd1); tick(9'd511, 1'b1, 1'b0);

    // Hold mode
    drive(1, 9'd5,   0, 0, 4'd7, 2'd2); tick(9'd5,   1'b0, 1'b0);
    drive(0, 9'd0,   1, 0, 4'd7, 2'd2); tick(9'd0,   1'b0, 1'b1);
    tick(9'd0, 1'b0, 1'b1);
    drive(0, 9'd0,   1, 0, 4'd0, 2'd2); tick(9'd0,   1'b0, 1'b0);
    drive(1, 9'd510, 0, 1, 4'd3, 2'd2); tick(9'd510, 1'b1, 1'b0);
    drive(0, 9'd0,   1, 1, 4'd3, 2'd2); tick(9'd511, 1'b1, 1'b1);

    // Preload beats enable, then run and reset asynchronously mid-cycle
    drive(1, 9'd100, 1, 1, 4'd3, 2'd0); tick(9'd100, 1'b1, 1'b0);
    drive(0, 9'd0,   1, 1, 4'd4, 2'd0); tick(9'd104, 1'b1, 1'b0);
    tick(9'd108, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("async_phase",   32'(phase),        32'd0);
    check("async_sample",  sample,            32'd0);
    check("async_valid",   32'(sample_valid), 32'd0);
    check("async_wrapped", 32'(wrapped),      32'd0);
    sb.delete();
    m_phase = '0;
    drive(0, 9'd0, 0, 1, 4'd0, 2'd0);
    @(negedge clk); reset = 1'b0;

    // Table survives reset: phase 20 -> index 10 -> 30
    drive(1, 9'd20, 0, 1, 4'd0, 2'd0); tick(9'd20, 1'b1, 1'b0);
    drive(0, 9'd0,  0, 1, 4'd0, 2'd0); tick(9'd20, 1'b1, 1'b0);
    tick(9'd20, 1'b1, 1'b0);
    check("mem10_after_reset", sample, 32'd30);

    // Read-during-write at index 20 returns old data first
    drive(1, 9'd40, 0, 1, 4'd0, 2'd0); tick(9'd40, 1'b1, 1'b0);
    drive(0, 9'd0,  0, 1, 4'd0, 2'd0);
    tbl_we = 1'b1; tbl_addr = 8'd20; tbl_din = 32'hDEADBEEF;
    tick(9'd40, 1'b1, 1'b0);
    tbl_we = 1'b0;
    tick(9'd40, 1'b1, 1'b0);
    check("rdw_old", sample, 32'd60);
    tick(9'd40, 1'b1, 1'b0);
    check("rdw_new", sample, 32'hDEADBEEF);
    tick(9'd40, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
